// File: rtl/seq_edge_event_serializer_if.sv
//------------------------------------------------------------------------------
// Module   : seq_edge_event_serializer_if
// Brief    : Valid/ready event handshake carrying the serialized bit index.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface seq_edge_event_serializer_if;
   logic       out_val;
   logic       out_rdy;
   logic [2:0] out_idx;

   modport master (
      output out_val,
      output out_idx,
      input  out_rdy
   );

   modport slave (
      input  out_val,
      input  out_idx,
      output out_rdy
   );
endinterface

`default_nettype wire

// File: rtl/seq_edge_event_serializer.sv
//------------------------------------------------------------------------------
// Module   : seq_edge_event_serializer
// Brief    : Round-robin serializer of an 8-bit edge mask into bit-index events.
//            Optional lost-event flags are built when EDGE_SER_OVF_EN is defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seq_edge_event_serializer (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [7:0]                  edges,
   seq_edge_event_serializer_if.master out,
   output logic [7:0]                  pending
`ifdef EDGE_SER_OVF_EN
   ,
   output logic [7:0]                  ovf,
   input  logic                        ovf_clr
`endif
);

   logic [7:0] r_pending;
   logic [2:0] r_ptr;

   logic [7:0] w_rot;
   logic [2:0] w_off;
   logic [2:0] w_idx;
   logic       w_grant;
   logic [7:0] w_gnt_vec;
   logic [7:0] w_pending_nxt;

   // Rotate pending so bit 0 is the one at ptr; the lowest set bit then wins.
   always_comb begin
      w_rot = 8'd0;
      for (int k = 0; k < 8; k++) begin
         w_rot[k] = r_pending[r_ptr + 3'(k)];
      end
   end

   always_comb begin
      w_off = 3'd0;
      for (int k = 7; k >= 0; k--) begin
         if (w_rot[k]) begin
            w_off = 3'(k);
         end
      end
   end

   assign w_idx         = r_ptr + w_off;
   assign out.out_val   = |r_pending;
   assign out.out_idx   = w_idx;
   assign w_grant       = out.out_val & out.out_rdy;
   assign w_gnt_vec     = w_grant ? (8'd1 << w_idx) : 8'd0;
   assign w_pending_nxt = (r_pending & ~w_gnt_vec) | edges;
   assign pending       = r_pending;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pending <= 8'd0;
         r_ptr     <= 3'd0;
      end else begin
         r_pending <= w_pending_nxt;
         if (w_grant) begin
            r_ptr <= w_idx + 3'd1;
         end
      end
   end

`ifdef EDGE_SER_OVF_EN
   logic [7:0] r_ovf;
   logic [7:0] w_loss;

   // An edge on a bit granted this cycle re-pends it and is not a loss.
   assign w_loss = edges & r_pending & ~w_gnt_vec;
   assign ovf    = r_ovf;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ovf <= 8'd0;
      end else if (ovf_clr) begin
         r_ovf <= w_loss;
      end else begin
         r_ovf <= r_ovf | w_loss;
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_seq_edge_event_serializer.sv
//------------------------------------------------------------------------------
// Module   : tb_seq_edge_event_serializer
// Brief    : Directed scoreboard bench for seq_edge_event_serializer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_seq_edge_event_serializer;

   logic       clk;
   logic       rst_n;
   logic [7:0] edges;
   logic [7:0] pending;
`ifdef EDGE_SER_OVF_EN
   logic [7:0] ovf;
   logic       ovf_clr;
`endif

   int         n_checks;
   int         n_fails;
   logic [2:0] exp_q[$];

   seq_edge_event_serializer_if u_if ();

   seq_edge_event_serializer dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .edges   (edges),
      .out     (u_if),
      .pending (pending)
`ifdef EDGE_SER_OVF_EN
      ,
      .ovf     (ovf),
      .ovf_clr (ovf_clr)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
      end
   endtask

   // Apply inputs for one cycle, then land 1 time unit after the next edge.
   task automatic step(input logic [7:0] e, input logic rdy);
      edges       = e;
      u_if.out_rdy = rdy;
      @(posedge clk);
      #1;
   endtask

   // Monitor: every accepted transfer must match the next queued index.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && u_if.out_val === 1'b1 && u_if.out_rdy === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL unexpected_grant: got idx %0d, expected no grant", u_if.out_idx);
         end else begin
            check("grant_idx", {5'd0, u_if.out_idx}, {5'd0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
      $fatal(1);
   end

   initial begin
      n_checks     = 0;
      n_fails      = 0;
      rst_n        = 1'b0;
      edges        = 8'h00;
      u_if.out_rdy = 1'b0;
`ifdef EDGE_SER_OVF_EN
      ovf_clr      = 1'b0;
`endif
      @(posedge clk);
      #1;
      step(8'h00, 1'b0);
      check("reset_pending", pending, 8'h00);
      check("reset_val", {7'd0, u_if.out_val}, 8'h00);
`ifdef EDGE_SER_OVF_EN
      check("reset_ovf", ovf, 8'h00);
`endif
      rst_n = 1'b1;

      // Idle with consumer ready
      repeat (5) begin
         step(8'h00, 1'b1);
         check("idle_val", {7'd0, u_if.out_val}, 8'h00);
         check("idle_pending", pending, 8'h00);
      end

      // Two edges, both ends of the vector
      exp_q.push_back(3'd0);
      exp_q.push_back(3'd7);
      step(8'h81, 1'b1);
      check("e81_val", {7'd0, u_if.out_val}, 8'h01);
      check("e81_idx0", {5'd0, u_if.out_idx}, 8'h00);
      step(8'h00, 1'b1);
      check("e81_idx7", {5'd0, u_if.out_idx}, 8'h07);
      step(8'h00, 1'b1);
      check("e81_done", {7'd0, u_if.out_val}, 8'h00);

      // Full burst drains in rotation at one per cycle
      for (int k = 0; k < 8; k++) exp_q.push_back(3'(k));
      step(8'hFF, 1'b1);
      check("burst_pending", pending, 8'hFF);
      repeat (8) step(8'h00, 1'b1);
      check("burst_done", {7'd0, u_if.out_val}, 8'h00);

      // Repeated edge on a stalled pending bit is a loss
      repeat (3) step(8'h04, 1'b0);
      step(8'h04, 1'b0);
      check("loss_pending", pending, 8'h04);
`ifdef EDGE_SER_OVF_EN
      check("loss_ovf", ovf, 8'h04);
      ovf_clr = 1'b1;
      step(8'h00, 1'b0);
      ovf_clr = 1'b0;
      check("ovf_cleared", ovf, 8'h00);
`endif
      exp_q.push_back(3'd2);
      step(8'h00, 1'b1);
      check("loss_drained", pending, 8'h00);

      // Edge on the bit being granted re-pends it (ptr=3 here)
      step(8'h10, 1'b0);
      exp_q.push_back(3'd4);
      exp_q.push_back(3'd4);
      step(8'h10, 1'b1);
      check("repend_pending", pending, 8'h10);
`ifdef EDGE_SER_OVF_EN
      check("repend_ovf", ovf, 8'h00);
`endif
      step(8'h00, 1'b1);
      check("repend_drained", pending, 8'h00);

      // Stall with ptr=5: later edges after idx in rotation leave idx alone
      step(8'h21, 1'b0);
      check("stall_idx_a", {5'd0, u_if.out_idx}, 8'h05);
      step(8'h40, 1'b0);
      check("stall_idx_b", {5'd0, u_if.out_idx}, 8'h05);
      check("stall_pending", pending, 8'h61);
      exp_q.push_back(3'd5);
      exp_q.push_back(3'd6);
      exp_q.push_back(3'd0);
      repeat (3) step(8'h00, 1'b1);
      check("rr_done", {7'd0, u_if.out_val}, 8'h00);

      // Mid-operation reset drops pending and returns ptr to 0
      step(8'h3C, 1'b0);
      check("pre_reset_pending", pending, 8'h3C);
      rst_n = 1'b0;
      step(8'hFF, 1'b0);
      check("mid_reset_pending", pending, 8'h00);
      check("mid_reset_val", {7'd0, u_if.out_val}, 8'h00);
`ifdef EDGE_SER_OVF_EN
      check("mid_reset_ovf", ovf, 8'h00);
`endif
      rst_n = 1'b1;
      exp_q.push_back(3'd0);
      exp_q.push_back(3'd7);
      step(8'h81, 1'b1);
      step(8'h00, 1'b1);
      step(8'h00, 1'b1);
      check("post_reset_done", {7'd0, u_if.out_val}, 8'h00);

      repeat (2) step(8'h00, 1'b0);
      check("queue_drained", 8'(exp_q.size()), 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

`default_nettype wire
